// File: rtl/inst_queue_if.sv
// inst_queue_if: fetch/ID1 side bundle of the instruction queue.
//   master: fetch + ID1 side (drives flush, push slots, pop requests)
//   slave : the queue (drives full/empty/count and the show-ahead head fields)
//   flush            : discard all entries
//   w_ena1/w_ena2    : push slot enables (slot 2 only with slot 1)
//   w_pc*/w_inst*    : pushed PCs / instruction words
//   w_exc*           : {i_invalid_tlbl, i_refill_tlbl, inst_adel}
//   full/empty/count : occupancy status
//   r_ena1/r_ena2    : pop requests (pop 2 only with r_ena1)
//   r_valid*/r_pc*/r_inst*/r_exc* : head and head+1 entries, zero when invalid
interface inst_queue_if #(
  parameter int PTR_W = 3
);
  logic             flush;
  logic             w_ena1;
  logic             w_ena2;
  logic [31:0]      w_pc1;
  logic [31:0]      w_pc2;
  logic [31:0]      w_inst1;
  logic [31:0]      w_inst2;
  logic [2:0]       w_exc1;
  logic [2:0]       w_exc2;
  logic             full;
  logic             empty;
  logic             r_ena1;
  logic             r_ena2;
  logic             r_valid1;
  logic             r_valid2;
  logic [31:0]      r_pc1;
  logic [31:0]      r_pc2;
  logic [31:0]      r_inst1;
  logic [31:0]      r_inst2;
  logic [2:0]       r_exc1;
  logic [2:0]       r_exc2;
  logic [PTR_W:0]   count;

  modport master (
    output flush, w_ena1, w_ena2, w_pc1, w_pc2, w_inst1, w_inst2, w_exc1, w_exc2,
    output r_ena1, r_ena2,
    input  full, empty, r_valid1, r_valid2, r_pc1, r_pc2, r_inst1, r_inst2,
    input  r_exc1, r_exc2, count
  );

  modport slave (
    input  flush, w_ena1, w_ena2, w_pc1, w_pc2, w_inst1, w_inst2, w_exc1, w_exc2,
    input  r_ena1, r_ena2,
    output full, empty, r_valid1, r_valid2, r_pc1, r_pc2, r_inst1, r_inst2,
    output r_exc1, r_exc2, count
  );
endinterface

// File: rtl/inst_queue.sv
// inst_queue: dual-ported circular instruction queue between fetch and ID1.
// Fetch pushes up to two entries per cycle, ID1 pops up to two per cycle from
// a show-ahead head. flush empties the queue in one cycle.
//   clk : clock, rising edge
//   rst : synchronous active-high reset (pointers and count only)
//   q   : inst_queue_if slave modport (push, pop, status, head fields)
module inst_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic          clk,
  input  logic          rst,
  inst_queue_if.slave   q
);

  localparam int ENTRY_W = 67;
  // full one entry early so a 2-wide fetch never lands half in the queue
  localparam logic [PTR_W:0] FULL_ABOVE = (PTR_W+1)'(DEPTH - 2);

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]   wp_r;
  logic [PTR_W-1:0]   rp_r;
  logic [PTR_W:0]     count_r;

  logic [PTR_W-1:0]   wp_nx_s;
  logic [PTR_W-1:0]   rp_nx_s;
  logic               full_s;
  logic               valid1_s;
  logic               valid2_s;
  logic [1:0]         n_w_s;
  logic [1:0]         n_r_s;
  logic [ENTRY_W-1:0] head1_s;
  logic [ENTRY_W-1:0] head2_s;

  assign wp_nx_s  = wp_r + PTR_W'(1);
  assign rp_nx_s  = rp_r + PTR_W'(1);
  assign full_s   = (count_r > FULL_ABOVE);
  assign valid1_s = (count_r != (PTR_W+1)'(0));
  assign valid2_s = (count_r > (PTR_W+1)'(1));
  assign head1_s  = mem_r[rp_r];
  assign head2_s  = mem_r[rp_nx_s];

  // Effective push/pop widths; flush blocks both, full blocks any push.
  always_comb begin
    n_w_s = 2'd0;
    n_r_s = 2'd0;
    if (q.flush) begin
      n_w_s = 2'd0;
      n_r_s = 2'd0;
    end else begin
      if (q.w_ena1 && !full_s) begin
        n_w_s = q.w_ena2 ? 2'd2 : 2'd1;
      end else begin
        n_w_s = 2'd0;
      end
      if (q.r_ena1 && q.r_ena2 && valid2_s) begin
        n_r_s = 2'd2;
      end else if (q.r_ena1 && valid1_s) begin
        n_r_s = 2'd1;
      end else begin
        n_r_s = 2'd0;
      end
    end
  end

  // Pointer and occupancy registers: rst beats flush beats traffic.
  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      wp_r    <= {PTR_W{1'b0}};
      rp_r    <= {PTR_W{1'b0}};
      count_r <= {(PTR_W+1){1'b0}};
    end else begin
      wp_r    <= wp_r + PTR_W'(n_w_s);
      rp_r    <= rp_r + PTR_W'(n_r_s);
      count_r <= count_r + (PTR_W+1)'(n_w_s) - (PTR_W+1)'(n_r_s);
    end
  end

  // Entry storage, deliberately not reset; slot 2 lands at wp+1 (wraps).
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (n_w_s != 2'd0) begin
        mem_r[wp_r] <= {q.w_pc1, q.w_inst1, q.w_exc1};
      end
      if (n_w_s == 2'd2) begin
        mem_r[wp_nx_s] <= {q.w_pc2, q.w_inst2, q.w_exc2};
      end
    end
  end

  // Show-ahead head outputs, zeroed whenever the slot is not valid.
  always_comb begin
    q.r_pc1   = 32'd0;
    q.r_inst1 = 32'd0;
    q.r_exc1  = 3'd0;
    q.r_pc2   = 32'd0;
    q.r_inst2 = 32'd0;
    q.r_exc2  = 3'd0;
    if (valid1_s) begin
      {q.r_pc1, q.r_inst1, q.r_exc1} = head1_s;
    end else begin
      {q.r_pc1, q.r_inst1, q.r_exc1} = {ENTRY_W{1'b0}};
    end
    if (valid2_s) begin
      {q.r_pc2, q.r_inst2, q.r_exc2} = head2_s;
    end else begin
      {q.r_pc2, q.r_inst2, q.r_exc2} = {ENTRY_W{1'b0}};
    end
  end

  assign q.full     = full_s;
  assign q.empty    = !valid1_s;
  assign q.r_valid1 = valid1_s;
  assign q.r_valid2 = valid2_s;
  assign q.count    = count_r;

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed self-checking bench for inst_queue (DEPTH = 8).
module tb_inst_queue;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  inst_queue_if #(.PTR_W(3)) qif ();

  inst_queue #(.DEPTH(8), .PTR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .q   (qif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    qif.flush  = 1'b0;
    qif.w_ena1 = 1'b0;
    qif.w_ena2 = 1'b0;
    qif.r_ena1 = 1'b0;
    qif.r_ena2 = 1'b0;
    qif.w_exc1 = 3'b000;
    qif.w_exc2 = 3'b000;
  endtask

  task automatic set_push(input logic e1, input logic e2,
                          input logic [31:0] pc1, input logic [31:0] pc2);
    qif.w_ena1  = e1;
    qif.w_ena2  = e2;
    qif.w_pc1   = pc1;
    qif.w_pc2   = pc2;
    qif.w_inst1 = ~pc1;
    qif.w_inst2 = ~pc2;
  endtask

  initial begin
    int pushed;
    int popped;
    int exp_cnt;
    int cyc;
    int wn;
    int rn;
    int acc_w;
    int acc_r;

    n_vec = 0;
    n_bad = 0;
    rst   = 1'b1;
    idle();
    set_push(1'b0, 1'b0, 32'd0, 32'd0);

    // reset held two cycles with random enables
    for (int i = 0; i < 2; i++) begin
      qif.w_ena1 = 1'($urandom_range(0, 1));
      qif.w_ena2 = 1'($urandom_range(0, 1));
      qif.r_ena1 = 1'($urandom_range(0, 1));
      qif.r_ena2 = 1'($urandom_range(0, 1));
      tick();
    end
    check("rst_count", 32'(qif.count), 32'd0);
    check("rst_empty", 32'(qif.empty), 32'd1);
    check("rst_full", 32'(qif.full), 32'd0);
    check("rst_valid1", 32'(qif.r_valid1), 32'd0);
    check("rst_valid2", 32'(qif.r_valid2), 32'd0);
    check("rst_pc1", qif.r_pc1, 32'd0);
    rst = 1'b0;
    idle();

    // 2-wide push then 2-wide pop
    set_push(1'b1, 1'b1, 32'hBFC0_0000, 32'hBFC0_0004);
    check("push_cycle_valid1", 32'(qif.r_valid1), 32'd0);
    tick();
    idle();
    check("push2_valid1", 32'(qif.r_valid1), 32'd1);
    check("push2_valid2", 32'(qif.r_valid2), 32'd1);
    check("push2_pc1", qif.r_pc1, 32'hBFC0_0000);
    check("push2_pc2", qif.r_pc2, 32'hBFC0_0004);
    check("push2_inst2", qif.r_inst2, 32'h403F_FFFB);
    check("push2_count", 32'(qif.count), 32'd2);
    qif.r_ena1 = 1'b1;
    qif.r_ena2 = 1'b1;
    tick();
    idle();
    check("pop2_empty", 32'(qif.empty), 32'd1);
    check("pop2_count", 32'(qif.count), 32'd0);
    check("pop2_pc1_zero", qif.r_pc1, 32'd0);

    // fill 1+2+2+2 -> count 7, full
    set_push(1'b1, 1'b0, 32'h100, 32'h0);
    tick();
    set_push(1'b1, 1'b1, 32'h104, 32'h108);
    tick();
    set_push(1'b1, 1'b1, 32'h10C, 32'h110);
    tick();
    check("fill5_count", 32'(qif.count), 32'd5);
    check("fill5_full", 32'(qif.full), 32'd0);
    set_push(1'b1, 1'b1, 32'h114, 32'h118);
    tick();
    check("fill7_count", 32'(qif.count), 32'd7);
    check("fill7_full", 32'(qif.full), 32'd1);
    check("fill7_empty", 32'(qif.empty), 32'd0);
    set_push(1'b1, 1'b1, 32'hDEAD_0000, 32'hDEAD_0004);
    tick();
    check("full_drop_count", 32'(qif.count), 32'd7);
    // push refused while full even with a pop in the same cycle
    set_push(1'b1, 1'b1, 32'hDEAD_0008, 32'hDEAD_000C);
    qif.r_ena1 = 1'b1;
    tick();
    idle();
    set_push(1'b0, 1'b0, 32'h0, 32'h0);
    check("full_pop_count", 32'(qif.count), 32'd6);
    check("full_pop_head", qif.r_pc1, 32'h104);
    check("full_pop_full", 32'(qif.full), 32'd0);
    // push 2 / pop 2 at count 6 across the wrap point
    set_push(1'b1, 1'b1, 32'h11C, 32'h120);
    qif.r_ena1 = 1'b1;
    qif.r_ena2 = 1'b1;
    tick();
    idle();
    set_push(1'b0, 1'b0, 32'h0, 32'h0);
    check("p2p2_count", 32'(qif.count), 32'd6);
    check("p2p2_head", qif.r_pc1, 32'h10C);
    check("p2p2_head2", qif.r_pc2, 32'h110);
    qif.r_ena1 = 1'b1;
    tick();
    idle();
    check("pre_flush_count", 32'(qif.count), 32'd5);

    // flush under full traffic
    qif.flush = 1'b1;
    set_push(1'b1, 1'b1, 32'hF00D_0000, 32'hF00D_0004);
    qif.r_ena1 = 1'b1;
    qif.r_ena2 = 1'b1;
    tick();
    idle();
    set_push(1'b0, 1'b0, 32'h0, 32'h0);
    check("flush_count", 32'(qif.count), 32'd0);
    check("flush_empty", 32'(qif.empty), 32'd1);
    check("flush_valid1", 32'(qif.r_valid1), 32'd0);
    check("flush_full", 32'(qif.full), 32'd0);
    tick();
    check("flush_no_pair", 32'(qif.count), 32'd0);

    // wrap-around: 20 entries, alternating 1/2 push and 2/1 pop
    pushed  = 0;
    popped  = 0;
    exp_cnt = 0;
    cyc     = 0;
    while (popped < 20 && cyc < 100) begin
      wn = (pushed < 20) ? ((cyc % 2 == 0) ? 1 : 2) : 0;
      if (wn == 2 && pushed == 19) wn = 1;
      rn = (cyc % 2 == 0) ? 2 : 1;
      set_push(wn >= 1, wn == 2, 32'h2000 + 32'(4 * pushed), 32'h2004 + 32'(4 * pushed));
      qif.r_ena1 = 1'b1;
      qif.r_ena2 = (rn == 2);
      acc_w = (exp_cnt <= 6) ? wn : 0;
      acc_r = (rn < exp_cnt) ? rn : exp_cnt;
      if (acc_r >= 1) check("wrap_pc1", qif.r_pc1, 32'h2000 + 32'(4 * popped));
      if (acc_r == 2) check("wrap_pc2", qif.r_pc2, 32'h2004 + 32'(4 * popped));
      tick();
      pushed  = pushed + acc_w;
      popped  = popped + acc_r;
      exp_cnt = exp_cnt + acc_w - acc_r;
      check("wrap_count", 32'(qif.count), 32'(exp_cnt));
      cyc = cyc + 1;
    end
    idle();
    set_push(1'b0, 1'b0, 32'h0, 32'h0);
    check("wrap_done", 32'(popped), 32'd20);
    check("wrap_empty", 32'(qif.empty), 32'd1);

    // edge reads: exception field, pop-2 with one entry
    set_push(1'b1, 1'b0, 32'h3000, 32'h0);
    qif.w_exc1 = 3'b010;
    tick();
    idle();
    set_push(1'b0, 1'b0, 32'h0, 32'h0);
    check("exc1", 32'(qif.r_exc1), 32'd2);
    check("one_valid2", 32'(qif.r_valid2), 32'd0);
    check("one_pc2_zero", qif.r_pc2, 32'd0);
    qif.r_ena1 = 1'b1;
    qif.r_ena2 = 1'b1;
    tick();
    idle();
    check("pop2_of_1_count", 32'(qif.count), 32'd0);

    // count 3 then r_ena2 alone and w_ena2 alone are ignored
    set_push(1'b1, 1'b0, 32'h4000, 32'h0);
    tick();
    set_push(1'b1, 1'b1, 32'h4004, 32'h4008);
    tick();
    set_push(1'b0, 1'b1, 32'hBAD0_0000, 32'hBAD0_0004);
    qif.r_ena2 = 1'b1;
    tick();
    idle();
    set_push(1'b0, 1'b0, 32'h0, 32'h0);
    check("ena2_only_count", 32'(qif.count), 32'd3);
    check("ena2_only_head", qif.r_pc1, 32'h4000);
    check("ena2_only_head2", qif.r_pc2, 32'h4004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
